// File: rtl/alu_arb_sched.sv
// alu_arb_sched: 4-requester round-robin arbiter in front of a small
// mul/add/div/sub unit. One operation in flight at a time:
// IDLE (grant + capture) -> EXEC (1 or DIV_LAT cycles) -> RESP (result pulse).
//
// Handshake: gnt is a one-cycle pulse, asserted combinationally in IDLE for the
// round-robin winner; the winner's operands are captured at that same edge, so
// the requester may drop req on the following cycle. res_valid is a one-cycle
// pulse in RESP; res_id/res_data/res_divz are qualified by it and hold their
// value otherwise. There is no back-pressure on the result.
module alu_arb_sched #(
   parameter int DIV_LAT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  req,
   input  logic [7:0]  req_op,
   input  logic [15:0] req_a,
   input  logic [15:0] req_b,
   output logic [3:0]  gnt,
   output logic        res_valid,
   output logic [1:0]  res_id,
   output logic [7:0]  res_data,
   output logic        res_divz,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [1:0] OP_MUL = 2'b00;
   localparam logic [1:0] OP_ADD = 2'b01;
   localparam logic [1:0] OP_DIV = 2'b10;
   localparam logic [1:0] OP_SUB = 2'b11;

   state_t      state;
   state_t      state_next;
   logic [1:0]  last_winner;
   logic [1:0]  win;
   logic        found;
   logic [1:0]  idx;
   logic [1:0]  op_q;
   logic [1:0]  id_q;
   logic [3:0]  cnt;
   logic [1:0]  sel_op;
   logic [3:0]  sel_a;
   logic [3:0]  sel_b;

   // Per-unit operand registers: only the selected unit ever sees non-zero data.
   logic [3:0]  mul_a, mul_b;
   logic [3:0]  add_a, add_b;
   logic [3:0]  sub_a, sub_b;
   logic [3:0]  div_a, div_b;

   logic [7:0]  mul_res, add_res, sub_res, div_res;
   logic [7:0]  result;
   logic        result_divz;

   assign busy = (state != IDLE);

   // Round-robin search starting one past the last winner; gnt only in IDLE.
   always_comb begin
      win   = 2'd0;
      found = 1'b0;
      idx   = 2'd0;
      for (int i = 0; i < 4; i++) begin
         idx = last_winner + 2'(i) + 2'd1;
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
      gnt = (state == IDLE && found && !rst) ? (4'b0001 << win) : 4'b0000;
   end

   assign sel_op = req_op[{win, 1'b0} +: 2];
   assign sel_a  = req_a[{win, 2'b00} +: 4];
   assign sel_b  = req_b[{win, 2'b00} +: 4];

   // Next-state: divide stays in EXEC for DIV_LAT cycles, everything else one.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (gnt != 4'b0000) state_next = EXEC;
         EXEC: if (op_q != OP_DIV || cnt == 4'(DIV_LAT - 1)) state_next = RESP;
         RESP: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Functional units and result select, driven from the isolated operands.
   always_comb begin
      mul_res     = {4'b0, mul_a} * {4'b0, mul_b};
      add_res     = {3'b0, {1'b0, add_a} + {1'b0, add_b}};
      sub_res     = {4'b0, sub_a} - {4'b0, sub_b};
      div_res     = (div_b == 4'd0) ? 8'hFF : {4'b0, div_a / div_b};
      result      = mul_res;
      result_divz = 1'b0;
      case (op_q)
         OP_MUL: result = mul_res;
         OP_ADD: result = add_res;
         OP_SUB: result = sub_res;
         OP_DIV: begin
            result      = div_res;
            result_divz = (div_b == 4'd0);
         end
         default: result = mul_res;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Capture on grant, count EXEC cycles, register the result into RESP.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_winner <= 2'd3;
         op_q        <= 2'd0;
         id_q        <= 2'd0;
         cnt         <= 4'd0;
         mul_a <= 4'd0; mul_b <= 4'd0;
         add_a <= 4'd0; add_b <= 4'd0;
         sub_a <= 4'd0; sub_b <= 4'd0;
         div_a <= 4'd0; div_b <= 4'd0;
         res_valid   <= 1'b0;
         res_id      <= 2'd0;
         res_data    <= 8'd0;
         res_divz    <= 1'b0;
      end else begin
         res_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (gnt != 4'b0000) begin
                  last_winner <= win;
                  id_q        <= win;
                  op_q        <= sel_op;
                  cnt         <= 4'd0;
                  mul_a <= (sel_op == OP_MUL) ? sel_a : 4'd0;
                  mul_b <= (sel_op == OP_MUL) ? sel_b : 4'd0;
                  add_a <= (sel_op == OP_ADD) ? sel_a : 4'd0;
                  add_b <= (sel_op == OP_ADD) ? sel_b : 4'd0;
                  sub_a <= (sel_op == OP_SUB) ? sel_a : 4'd0;
                  sub_b <= (sel_op == OP_SUB) ? sel_b : 4'd0;
                  div_a <= (sel_op == OP_DIV) ? sel_a : 4'd0;
                  div_b <= (sel_op == OP_DIV) ? sel_b : 4'd0;
               end
            end
            EXEC: begin
               cnt <= cnt + 4'd1;
               if (state_next == RESP) begin
                  res_valid <= 1'b1;
                  res_id    <= id_q;
                  res_data  <= result;
                  res_divz  <= result_divz;
               end
            end
            RESP: begin
               mul_a <= 4'd0; mul_b <= 4'd0;
               add_a <= 4'd0; add_b <= 4'd0;
               sub_a <= 4'd0; sub_b <= 4'd0;
               div_a <= 4'd0; div_b <= 4'd0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arb_sched.sv
// Directed bench for alu_arb_sched: the driver issues requests and pushes the
// hand-computed result into exp_q; a monitor pops on every res_valid and also
// checks the per-cycle grant and operand-isolation invariants.
module tb_alu_arb_sched;

   localparam int DIV_LAT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [7:0]  req_op;
   logic [15:0] req_a;
   logic [15:0] req_b;
   logic [3:0]  gnt;
   logic        res_valid;
   logic [1:0]  res_id;
   logic [7:0]  res_data;
   logic        res_divz;
   logic        busy;

   // Entry: {grant cycle[15:0], latency[4:0], id[1:0], data[7:0], divz}
   logic [31:0] exp_q[$];
   int          n_vec  = 0;
   int          n_fail = 0;
   int          cyc    = 0;
   logic        chk_en = 1'b0;

   alu_arb_sched #(.DIV_LAT(DIV_LAT)) dut (
      .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_a(req_a),
      .req_b(req_b), .gnt(gnt), .res_valid(res_valid), .res_id(res_id),
      .res_data(res_data), .res_divz(res_divz), .busy(busy)
   );

   // Clock and cycle counter.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1, "timeout");
   end

   function automatic logic [31:0] mk(input int gc, input int lat, input int id,
                                      input int data, input bit divz);
      return {16'(gc), 5'(lat), 2'(id), 8'(data), divz};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_vec++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   // Wait (bounded) for a grant and check it went to the expected requester.
   task automatic grant_wait(input logic [3:0] eg, output int gc);
      int n = 0;
      @(negedge clk);
      while (gnt == 4'b0000 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("gnt", {28'b0, gnt}, {28'b0, eg});
      gc = cyc;
   endtask

   task automatic set_req(input int id, input int op, input int a, input int b);
      req_op[2*id +: 2] = 2'(op);
      req_a[4*id +: 4]  = 4'(a);
      req_b[4*id +: 4]  = 4'(b);
   endtask

   task automatic single_op(input int id, input int op, input int a, input int b,
                            input int data, input bit divz, input int lat);
      int gc;
      @(posedge clk); #1;
      set_req(id, op, a, b);
      req = 4'(1 << id);
      grant_wait(4'(1 << id), gc);
      exp_q.push_back(mk(gc, lat, id, data, divz));
      @(posedge clk); #1;
      req = 4'b0000;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("drain", 32'(exp_q.size()), 32'd0);
   endtask

   // Monitor: invariants every cycle, scoreboard pop on each result pulse.
   initial begin
      logic [31:0] e;
      logic        iso_ok;
      forever begin
         @(negedge clk);
         if (chk_en) begin
            check("gnt_onehot0", {31'b0, $onehot0(gnt)}, 32'd1);
            if (gnt != 4'b0000) check("gnt_in_idle", {30'b0, dut.state}, 32'd0);
            iso_ok = 1'b1;
            if (dut.state == 2'd0 || dut.op_q != 2'b00) iso_ok &= (dut.mul_a == 0 && dut.mul_b == 0);
            if (dut.state == 2'd0 || dut.op_q != 2'b01) iso_ok &= (dut.add_a == 0 && dut.add_b == 0);
            if (dut.state == 2'd0 || dut.op_q != 2'b10) iso_ok &= (dut.div_a == 0 && dut.div_b == 0);
            if (dut.state == 2'd0 || dut.op_q != 2'b11) iso_ok &= (dut.sub_a == 0 && dut.sub_b == 0);
            check("isolation", {31'b0, iso_ok}, 32'd1);
            if (res_valid) begin
               if (exp_q.size() == 0) begin
                  check("res_unexpected", {31'b0, res_valid}, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  check("res_id",   {30'b0, res_id},   {30'b0, e[10:9]});
                  check("res_data", {24'b0, res_data}, {24'b0, e[8:1]});
                  check("res_divz", {31'b0, res_divz}, {31'b0, e[0]});
                  check("latency",  32'(16'(cyc) - e[31:16]), {27'b0, e[15:11]});
               end
            end
         end
      end
   end

   // Directed stimulus.
   initial begin
      int gc, gp, rc;
      rst = 1'b1; req = 4'b0; req_op = 8'b0; req_a = 16'b0; req_b = 16'b0;
      repeat (3) @(posedge clk);
      #1 chk_en = 1'b1;
      @(negedge clk);
      check("rst_gnt",       {28'b0, gnt},       32'd0);
      check("rst_busy",      {31'b0, busy},      32'd0);
      check("rst_res_valid", {31'b0, res_valid}, 32'd0);
      check("rst_res_id",    {30'b0, res_id},    32'd0);
      check("rst_res_data",  {24'b0, res_data},  32'd0);
      check("rst_res_divz",  {31'b0, res_divz},  32'd0);

      // Round robin with all four adds held: order 0,1,2,3,0, grant every 3rd cycle.
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) set_req(i, 1, i + 1, 2 * i + 3);
      req = 4'b1111;
      gp = 0;
      for (int k = 0; k < 5; k++) begin
         grant_wait(4'(1 << (k % 4)), gc);
         if (k > 0) check("rr_gap", 32'(gc - gp), 32'd3);
         exp_q.push_back(mk(gc, 2, k % 4, 3 * (k % 4) + 4, 1'b0));
         gp = gc;
      end
      @(posedge clk); #1;
      req = 4'b0000;

      single_op(0, 0, 7, 9, 63, 1'b0, 2);        // mul 7*9
      single_op(2, 3, 3, 5, 8'hFE, 1'b0, 2);     // sub 3-5
      single_op(1, 2, 13, 0, 8'hFF, 1'b1, 5);    // div by zero
      single_op(1, 2, 13, 4, 3, 1'b0, 5);        // div 13/4
      single_op(3, 0, 15, 15, 225, 1'b0, 2);     // mul max
      single_op(0, 1, 15, 15, 30, 1'b0, 2);      // add max (5-bit carry)
      single_op(2, 2, 15, 1, 15, 1'b0, 5);       // div by one
      single_op(1, 3, 0, 15, 8'hF1, 1'b0, 2);    // sub 0-15
      single_op(3, 2, 0, 7, 0, 1'b0, 5);         // div zero dividend
      drain();

      // Reset in the middle of a divide: no result, then fresh round robin.
      @(posedge clk); #1;
      set_req(1, 2, 13, 4);
      req = 4'b0010;
      grant_wait(4'b0010, gc);
      @(posedge clk); #1;
      req = 4'b0000;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      rc = cyc;
      set_req(0, 1, 1, 2);
      set_req(3, 0, 2, 3);
      req = 4'b1001;
      grant_wait(4'b0001, gc);
      check("post_rst_gnt_cycle", 32'(gc - rc), 32'd0);
      check("post_rst_busy",      {31'b0, busy},      32'd0);
      check("post_rst_res_valid", {31'b0, res_valid}, 32'd0);
      check("post_rst_res_data",  {24'b0, res_data},  32'd0);
      exp_q.push_back(mk(gc, 2, 0, 3, 1'b0));
      @(posedge clk); #1;
      req = 4'b1000;
      gp = gc;
      grant_wait(4'b1000, gc);
      check("post_rst_gap", 32'(gc - gp), 32'd3);
      exp_q.push_back(mk(gc, 2, 3, 6, 1'b0));
      @(posedge clk); #1;
      req = 4'b0000;
      drain();
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
